// File: rtl/axi_mem_pkg.sv
// Shared types and constants for the 64-bit AXI memory responder.
// Response codes are ordered so that a numeric max picks the most severe one.
package axi_mem_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_DATA  = 2'd2
    } r_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int BEAT_BYTES = 8;

    // True when addr maps onto a RAM word; the 33-bit difference catches addr < base.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] depth);
        logic [32:0] diff;
        diff = {1'b0, addr} - {1'b0, base};
        return !diff[32] && ((diff[31:0] >> 3) < depth);
    endfunction

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mem_sp_64.sv
// Single-port 64-bit RAM with per-byte write enables and one-cycle read latency.
// Contents are deliberately not reset.
module mem_sp_64 #(
    parameter int unsigned DEPTH = 8192,
    parameter int          AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [7:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] mem [DEPTH];
    logic [63:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        for (int k = 0; k < 8; k++) begin
            if (en && we && be[k]) begin
                mem[addr][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi_mem_responder_64.sv
// AXI-style INCR-only memory slave: one write and one read burst in flight,
// both sharing a single-port RAM where a write beat always beats a read fetch.
//
// state   | meaning
// W_IDLE  | waiting for AW, o_aw_ready high
// W_DATA  | accepting write beats until len+1 have arrived
// W_RESP  | presenting B response
// R_IDLE  | waiting for AR, o_ar_ready high
// R_FETCH | RAM read issued (retried if a write beat owns the RAM)
// R_DATA  | presenting R beat, held until i_r_ready
module axi_mem_responder_64
    import axi_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 8192,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  i_aw_id,
    input  logic [31:0] i_aw_addr,
    input  logic [7:0]  i_aw_len,
    input  logic        i_aw_valid,
    output logic        o_aw_ready,
    input  logic [63:0] i_w_data,
    input  logic [7:0]  i_w_strb,
    input  logic        i_w_last,
    input  logic        i_w_valid,
    output logic        o_w_ready,
    output logic [5:0]  o_b_id,
    output logic [1:0]  o_b_resp,
    output logic        o_b_valid,
    input  logic        i_b_ready,
    input  logic [5:0]  i_ar_id,
    input  logic [31:0] i_ar_addr,
    input  logic [7:0]  i_ar_len,
    input  logic        i_ar_valid,
    output logic        o_ar_ready,
    output logic [5:0]  o_r_id,
    output logic [63:0] o_r_data,
    output logic [1:0]  o_r_resp,
    output logic        o_r_last,
    output logic        o_r_valid,
    input  logic        i_r_ready
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    w_state_e    w_state_q, w_state_d;
    logic [5:0]  aw_id_q, aw_id_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic [7:0]  w_len_q, w_len_d;
    logic [7:0]  w_cnt_q, w_cnt_d;
    logic [1:0]  w_resp_q, w_resp_d;

    r_state_e    r_state_q, r_state_d;
    logic [5:0]  ar_id_q, ar_id_d;
    logic [31:0] r_addr_q, r_addr_d;
    logic [7:0]  r_len_q, r_len_d;
    logic [7:0]  r_cnt_q, r_cnt_d;
    logic [1:0]  r_resp_q, r_resp_d;
    logic        r_last_q, r_last_d;

    logic          w_hs, w_ok, r_ok, r_fetch_go;
    logic [1:0]    w_beat_resp;
    logic          ram_en, ram_we;
    logic [7:0]    ram_be;
    logic [AW-1:0] ram_addr;
    logic [63:0]   ram_rdata;

    always_comb begin
        w_hs       = (w_state_q == W_DATA) && i_w_valid;
        w_ok       = addr_in_range(w_addr_q, BASE_ADDR, 32'(DEPTH_WORDS));
        r_ok       = addr_in_range(r_addr_q, BASE_ADDR, 32'(DEPTH_WORDS));
        r_fetch_go = !w_hs || !r_ok;

        ram_en   = w_hs || ((r_state_q == R_FETCH) && r_ok);
        ram_we   = w_hs;
        ram_be   = w_ok ? i_w_strb : 8'h00;
        ram_addr = w_hs ? AW'((w_addr_q - BASE_ADDR) >> 3)
                        : AW'((r_addr_q - BASE_ADDR) >> 3);
    end

    always_comb begin
        w_state_d   = w_state_q;
        aw_id_d     = aw_id_q;
        w_addr_d    = w_addr_q;
        w_len_d     = w_len_q;
        w_cnt_d     = w_cnt_q;
        w_resp_d    = w_resp_q;
        w_beat_resp = RESP_OKAY;
        case (w_state_q)
            W_IDLE: begin
                if (i_aw_valid) begin
                    aw_id_d   = i_aw_id;
                    w_addr_d  = i_aw_addr & ~32'h7;
                    w_len_d   = i_aw_len;
                    w_cnt_d   = 8'd0;
                    w_resp_d  = RESP_OKAY;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    // Burst length is set by AW; a misplaced w_last only degrades the response.
                    if (!w_ok) begin
                        w_beat_resp = RESP_DECERR;
                    end else if (i_w_last != (w_cnt_q == w_len_q)) begin
                        w_beat_resp = RESP_SLVERR;
                    end
                    w_resp_d = resp_max(w_resp_q, w_beat_resp);
                    w_addr_d = w_addr_q + 32'(BEAT_BYTES);
                    w_cnt_d  = w_cnt_q + 8'd1;
                    if (w_cnt_q == w_len_q) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (i_b_ready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        ar_id_d   = ar_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_resp_d  = r_resp_q;
        r_last_d  = r_last_q;
        case (r_state_q)
            R_IDLE: begin
                if (i_ar_valid) begin
                    ar_id_d   = i_ar_id;
                    r_addr_d  = i_ar_addr & ~32'h7;
                    r_len_d   = i_ar_len;
                    r_cnt_d   = 8'd0;
                    r_state_d = R_FETCH;
                end
            end
            R_FETCH: begin
                if (r_fetch_go) begin
                    r_resp_d  = r_ok ? RESP_OKAY : RESP_DECERR;
                    r_last_d  = (r_cnt_q == r_len_q);
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (i_r_ready) begin
                    if (r_last_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d   = r_cnt_q + 8'd1;
                        r_addr_d  = r_addr_q + 32'(BEAT_BYTES);
                        r_state_d = R_FETCH;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            aw_id_q   <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_resp_q  <= RESP_OKAY;
            r_state_q <= R_IDLE;
            ar_id_q   <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_resp_q  <= RESP_OKAY;
            r_last_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            aw_id_q   <= aw_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_resp_q  <= w_resp_d;
            r_state_q <= r_state_d;
            ar_id_q   <= ar_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_resp_q  <= r_resp_d;
            r_last_q  <= r_last_d;
        end
    end

    mem_sp_64 #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (i_w_data),
        .rdata (ram_rdata)
    );

    assign o_aw_ready = (w_state_q == W_IDLE);
    assign o_w_ready  = (w_state_q == W_DATA);
    assign o_b_valid  = (w_state_q == W_RESP);
    assign o_b_id     = aw_id_q;
    assign o_b_resp   = w_resp_q;

    assign o_ar_ready = (r_state_q == R_IDLE);
    assign o_r_valid  = (r_state_q == R_DATA);
    assign o_r_id     = ar_id_q;
    assign o_r_resp   = r_resp_q;
    assign o_r_last   = r_last_q;
    // Decode-error beats never touched the RAM, so their data is forced to zero.
    assign o_r_data   = ((r_state_q == R_DATA) && (r_resp_q == RESP_OKAY)) ? ram_rdata : 64'h0;

endmodule

// File: doc/axi_mem_responder_64.md
AXI_MEM_RESPONDER_64 -- requirements
Module: axi_mem_responder_64

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 8192: number of 64-bit words in backing RAM (64 kB).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_aw_id  input  6  write transaction ID.
REQ-006 SHALL have port i_aw_addr  input  32  write burst start byte address.
REQ-007 SHALL have port i_aw_len  input  8  write beats minus one.
REQ-008 SHALL have port i_aw_valid  input  1  AW valid.
REQ-009 SHALL have port o_aw_ready  output  1  AW ready.
REQ-010 SHALL have port i_w_data  input  64  write beat data.
REQ-011 SHALL have port i_w_strb  input  8  byte enables.
REQ-012 SHALL have port i_w_last  input  1  final write beat.
REQ-013 SHALL have port i_w_valid  input  1  W valid.
REQ-014 SHALL have port o_w_ready  output  1  W ready.
REQ-015 SHALL have port o_b_id  output  6  echoed write ID.
REQ-016 SHALL have port o_b_resp  output  2  write response.
REQ-017 SHALL have port o_b_valid  output  1  B valid.
REQ-018 SHALL have port i_b_ready  input  1  B ready.
REQ-019 SHALL have port i_ar_id  input  6  read transaction ID.
REQ-020 SHALL have port i_ar_addr  input  32  read burst start byte address.
REQ-021 SHALL have port i_ar_len  input  8  read beats minus one.
REQ-022 SHALL have port i_ar_valid  input  1  AR valid.
REQ-023 SHALL have port o_ar_ready  output  1  AR ready.
REQ-024 SHALL have port o_r_id  output  6  echoed read ID.
REQ-025 SHALL have port o_r_data  output  64  read beat data.
REQ-026 SHALL have port o_r_resp  output  2  read response.
REQ-027 SHALL have port o_r_last  output  1  final read beat.
REQ-028 SHALL have port o_r_valid  output  1  R valid.
REQ-029 SHALL have port i_r_ready  input  1  R ready.

Function
REQ-030 SHALL treat all bursts as INCR, 8-byte beats; beat n address = start (bits [2:0] ignored) + 8n; word index = (addr - BASE_ADDR)>>3.
REQ-031 SHALL flag a beat DECERR (2'b11) when its word index >= DEPTH_WORDS or addr < BASE_ADDR; such writes dropped, such reads return 64'h0.
REQ-032 SHALL run write FSM W_IDLE->W_DATA on AW handshake (capture id/addr/len; o_aw_ready=1 only in W_IDLE), W_DATA->W_RESP on beat len+1, W_RESP->W_IDLE on B handshake.
REQ-033 SHALL assert o_w_ready only in W_DATA; each handshake writes bytes with i_w_strb[k]=1 only; strb 8'h00 writes nothing.
REQ-034 SHALL return o_b_resp = most severe beat response (DECERR > SLVERR > OKAY); i_w_last mismatching beat count = SLVERR, burst ends at count len+1 regardless.
REQ-035 SHALL run read FSM R_IDLE->R_FETCH on AR handshake (o_ar_ready=1 only in R_IDLE), R_FETCH->R_DATA after one-cycle RAM read, R_DATA->R_FETCH (next beat) or R_IDLE (last beat) on R handshake.
REQ-036 SHALL give first o_r_valid two cycles after AR handshake; o_r_last=1 exactly on beat len; R outputs held stable while o_r_valid && !i_r_ready.
REQ-037 SHALL share one single-port RAM; a write beat and a read fetch in the same cycle: write wins, fetch retries next cycle (read-after-write returns new data).
REQ-038 SHALL accept AW and AR in the same cycle independently; one outstanding write and one outstanding read maximum.

Reset
REQ-039 SHALL on rst force W_IDLE/R_IDLE, abandon in-flight bursts, drive all valid outputs 0, o_aw_ready=o_ar_ready=1, o_w_ready=0, id/data/resp/last outputs 0.
REQ-040 SHALL NOT clear RAM contents on reset.

Structure
REQ-041 SHALL take write/read state enums, RESP_OKAY/SLVERR/DECERR codes and BEAT_BYTES=8 from shared package axi_mem_pkg.
REQ-042 SHALL instantiate sub-module mem_sp_64 (single-port, byte-enabled, 1-cycle read latency RAM).

Verification
REQ-043 SHALL cover: AW id=5 addr=0x100 len=3, 4 beats strb=FF -> B id=5 resp=OKAY; AR addr=0x100 len=3 -> same 4 words, last on beat 3.
REQ-044 SHALL cover: write 0x1122334455667788 strb=0x0F over 0 -> read returns 0x0000000055667788.
REQ-045 SHALL cover: AR addr=DEPTH_WORDS*8-8 len=1 -> beat0 OKAY, beat1 DECERR data 0.
REQ-046 SHALL cover: i_r_ready low 5 cycles mid-burst -> R outputs stable, no beat lost; AW and AR same cycle -> both accepted.
REQ-047 SHALL cover: w_last on beat 1 of len=2 -> resp SLVERR; rst mid-read -> o_r_valid 0 next, FSMs idle, RAM data kept.
